// File: rtl/ssd_scan_multi_if.sv
// Display-side bundle for the multiplexed seven-segment scanner.
// No handshake: inputs are sampled once per frame; outputs are registered pins plus scan status.
interface ssd_scan_multi_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lead_zeros;
  logic [PWM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              cathodes;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_tick;

  modport master (
    output digits, dp_in, digit_en, blank_lead_zeros, brightness,
    input  an, cathodes, scan_idx, frame_tick
  );

  modport slave (
    input  digits, dp_in, digit_en, blank_lead_zeros, brightness,
    output an, cathodes, scan_idx, frame_tick
  );
endinterface

// File: rtl/ssd_scan_multi.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame data snapshot,
// leading-zero blanking, PWM brightness and an anode-off guard at the start of each dwell.
module ssd_scan_multi #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_BITS   = 18,
  parameter int PWM_BITS     = 4,
  parameter int GUARD_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_multi_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DWELL_BITS-1:0] PRE_MAX  = '1;
  localparam logic [DWELL_BITS-1:0] GUARD    = DWELL_BITS'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DWELL_BITS-1:0]   prescaler;
  logic [IDX_W-1:0]        scan_idx;
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_en;
  logic                    snap_blank;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [7:0]              cath_q;
  logic                    tick_q;

  logic [NUM_DIGITS-1:0]   visible;
  logic                    zeros_above;
  logic [3:0]              eff_nib;
  logic [3:0]              cur_nib;
  logic                    cur_vis;
  logic                    cur_dp;
  logic                    drive;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              cath_next;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Walk from the most significant digit down; a disabled digit counts as zero.
  always_comb begin
    zeros_above = 1'b1;
    eff_nib     = 4'h0;
    visible     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      eff_nib     = snap_en[k] ? snap_digits[4*k +: 4] : 4'h0;
      zeros_above = zeros_above && (eff_nib == 4'h0);
      visible[k]  = snap_en[k] && !(snap_blank && (k != 0) && zeros_above);
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_vis = 1'b0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        cur_nib = snap_digits[4*k +: 4];
        cur_vis = visible[k];
        cur_dp  = snap_dp[k];
      end
    end
    drive = (cur_vis || cur_dp) && (prescaler >= GUARD) &&
            (prescaler[PWM_BITS-1:0] < bus.brightness);
    an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_next[k] = !(drive && (scan_idx == IDX_W'(k)));
    end
    cath_next = {(cur_vis ? seg7(cur_nib) : 7'h7F), ~cur_dp};
  end

  // The snapshot loads on the last cycle of the last digit, so a frame always starts at digit 0 with fresh data.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      scan_idx    <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_blank  <= 1'b0;
      an_q        <= '1;
      cath_q      <= 8'hFF;
      tick_q      <= 1'b0;
    end else begin
      prescaler <= prescaler + 1'b1;
      tick_q    <= 1'b0;
      if (prescaler == PRE_MAX) begin
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        if (scan_idx == LAST_IDX) begin
          snap_digits <= bus.digits;
          snap_dp     <= bus.dp_in;
          snap_en     <= bus.digit_en;
          snap_blank  <= bus.blank_lead_zeros;
          tick_q      <= 1'b1;
        end
      end
      an_q   <= an_next;
      cath_q <= cath_next;
    end
  end

  assign bus.an         = an_q;
  assign bus.cathodes   = cath_q;
  assign bus.scan_idx   = scan_idx;
  assign bus.frame_tick = tick_q;
endmodule

// File: doc/ssd_scan_multi.md
Name: ssd_scan_multi

Overview:
- Parametrised seven-segment scan controller; successor to the fixed 4-digit, hard-wired-anode scanner in the top level.
- Drives NUM_DIGITS common-anode digits, time-multiplexed. Adds per-digit enable, per-digit decimal point, leading-zero blanking, PWM brightness and an inter-digit ghosting guard.
- Input data is snapshotted once per frame, so a digit never changes mid-frame (no tearing).
- Sits between game/status logic and the board Ca..Cg/Dp/An pins.

Parameters:
- NUM_DIGITS, 8: digit count, 2..8.
- DWELL_BITS, 18: each digit is scanned for 2^DWELL_BITS clk cycles.
- PWM_BITS, 4: brightness resolution. Must be <= DWELL_BITS.
- GUARD_CYCLES, 16: anodes forced off for the first GUARD_CYCLES cycles of each dwell. Must be < 2^DWELL_BITS.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- rst  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point request per digit (1 = lit).
- digit_en  in  NUM_DIGITS  per-digit enable (0 = dark).
- blank_lead_zeros  in  1  suppress leading zeros.
- brightness  in  PWM_BITS  0 = dark, max = (2^PWM_BITS-1)/2^PWM_BITS duty.
- an  out  NUM_DIGITS  anodes, active low.
- cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active low.
- scan_idx  out  clog2(NUM_DIGITS)  digit currently scanned (pre-register).
- frame_tick  out  1  one-cycle pulse when the snapshot loads.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - prescaler=0, scan_idx=0, snapshot regs (digits, dp, en, blank flag) = 0.
  - an = all 1s, cathodes = 8'hFF, frame_tick = 0.
  - Reset asserted mid-dwell aborts the scan immediately; outputs are dark on the next edge.
- Prescaler:
  - DWELL_BITS-wide up-counter; wraps from max to 0.
  - At prescaler==max: scan_idx <= (scan_idx==NUM_DIGITS-1) ? 0 : scan_idx+1.
- Snapshot:
  - Loaded from inputs at prescaler==max && scan_idx==NUM_DIGITS-1, so the new frame begins at digit 0 with new data.
  - frame_tick is asserted in the cycle after the load.
  - brightness is sampled live, not snapshotted.
- Digit visibility: digit k is visible when snapshot en[k]=1 and k is not leading-blanked.
- Leading-zero blanking (blank flag=1):
  - Digit k is blanked if k>0 and every snapshot nibble at index >= k is 0 (only enabled digits are considered; disabled digits count as zero).
  - Digit 0 is never blanked.
  - A blanked digit with dp=1 shows only Dp.
- Anode drive for digit scan_idx is active (0) only when all of the following hold:
  - the digit is visible or its dp is lit;
  - prescaler >= GUARD_CYCLES;
  - prescaler[PWM_BITS-1:0] < brightness.
  - All other anodes are 1.
- Disabled digits still consume their dwell slot, keeping duty constant across digits.
- Cathode decode (abcdefg, active low), standard team table:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
  - Blanked digit: segments 1111111.
  - Dp bit = ~dp[scan_idx].
- Latency: an and cathodes are registered, lagging scan_idx and prescaler by exactly 1 cycle.
- Glitch-free outputs: no combinational path from inputs to pins.

Test Plan:
(Bench uses NUM_DIGITS=4, DWELL_BITS=5, PWM_BITS=2, GUARD_CYCLES=2.)
- Reset held 3 cycles, then released with digits=16'h1234, en=4'hF, brightness=3:
  - an=4'hF and cathodes=8'hFF until the first frame_tick (cycle 128 after release).
  - Then digit0 shows "4" (cathodes 10011001) with an=1110 at prescaler 2..31 wherever prescaler[1:0]<3.
- Scan order and guard: an cycles 1110→1101→1011→0111→1110, each for 32 cycles; an=1111 for the first 2 cycles (+1 register lag) of every dwell.
- Leading-zero blanking: digits=16'h0050, blank=1, dp=4'b1000:
  - digit3 shows only Dp (cathodes 11111110);
  - digit2 is dark (an stays 1);
  - digit1 shows "5"; digit0 shows "0".
- Brightness: brightness=0 → an all 1s for the entire frame; brightness=1 → each digit active 1 of every 4 cycles outside the guard.
- Snapshot: change digits mid-frame (at digit1) → displayed values are unchanged until scan_idx wraps to 0; frame_tick pulses exactly once per 128 cycles.
- Reset asserted at prescaler=17 of digit2 → next edge an=4'hF, cathodes=8'hFF, scan_idx=0; the scan restarts cleanly after release.
